// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, branch/jump redirect with one-cycle flush, redirect counter.
// Optional jump-register redirect is enabled by defining PC_SEQ_JR_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             br_req_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_pc4_i,
  input  logic [31:0]      br_imm_i,
  input  logic             jmp_req_i,
  input  logic [31:0]      jmp_pc4_i,
  input  logic [25:0]      jmp_addr_i,
`ifdef PC_SEQ_JR_EN
  input  logic             jr_req_i,
  input  logic [31:0]      jr_addr_i,
`endif
  output logic [31:0]      pc_o,
  output logic [31:0]      pc4_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  // state | meaning
  // RUN   | normal fetch; branch > (jr) > jump > stall > pc+4
  // FLUSH | one cycle after a redirect; kill IF/ID and ID/EX, ignore requests, pc+4
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [31:2]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             redirect;
  logic             br_take;
  logic [31:0]      br_tgt;
  logic [31:0]      jmp_tgt;

  // The PC is held word-aligned by construction: only bits [31:2] are stored.
  assign pc_o    = {pc_q, 2'b00};
  assign pc4_o   = pc_o + 32'd4;
  assign br_take = br_req_i & br_taken_i;
  assign br_tgt  = br_pc4_i + {br_imm_i[29:0], 2'b00};
  assign jmp_tgt = {jmp_pc4_i[31:28], jmp_addr_i, 2'b00};

  assign flush_if_o     = (state_q == FLUSH);
  assign flush_id_o     = (state_q == FLUSH);
  assign redirect_cnt_o = cnt_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redirect = 1'b0;
    case (state_q)
      RUN: begin
        if (br_take) begin
          pc_d     = br_tgt[31:2];
          redirect = 1'b1;
        end
`ifdef PC_SEQ_JR_EN
        else if (jr_req_i) begin
          pc_d     = jr_addr_i[31:2];
          redirect = 1'b1;
        end
`endif
        else if (jmp_req_i) begin
          pc_d     = jmp_tgt[31:2];
          redirect = 1'b1;
        end else if (!stall_i) begin
          pc_d = pc4_o[31:2];
        end
        if (redirect) state_d = FLUSH;
      end
      FLUSH: begin
        // Wrong-path requests and stall are both ignored here.
        pc_d    = pc4_o[31:2];
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC[31:2];
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  logic unused_bits;
`ifdef PC_SEQ_JR_EN
  assign unused_bits = ^{br_imm_i[31:30], jmp_pc4_i[27:0], br_tgt[1:0], jmp_tgt[1:0], pc4_o[1:0], jr_addr_i[1:0]};
`else
  assign unused_bits = ^{br_imm_i[31:30], jmp_pc4_i[27:0], br_tgt[1:0], jmp_tgt[1:0], pc4_o[1:0]};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default instance plus a CNT_W=2 instance sharing stimulus.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_req_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_pc4_i = '0;
  logic [31:0] br_imm_i = '0;
  logic        jmp_req_i = 1'b0;
  logic [31:0] jmp_pc4_i = '0;
  logic [25:0] jmp_addr_i = '0;
`ifdef PC_SEQ_JR_EN
  logic        jr_req_i = 1'b0;
  logic [31:0] jr_addr_i = '0;
`endif
  logic [31:0] pc_o, pc4_o, pc_s, pc4_s;
  logic        flush_if_o, flush_id_o, fif_s, fid_s;
  logic [15:0] cnt_o;
  logic [1:0]  cnt_s;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .br_req_i(br_req_i), .br_taken_i(br_taken_i),
    .br_pc4_i(br_pc4_i), .br_imm_i(br_imm_i), .jmp_req_i(jmp_req_i), .jmp_pc4_i(jmp_pc4_i),
    .jmp_addr_i(jmp_addr_i),
`ifdef PC_SEQ_JR_EN
    .jr_req_i(jr_req_i), .jr_addr_i(jr_addr_i),
`endif
    .pc_o(pc_o), .pc4_o(pc4_o), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
    .redirect_cnt_o(cnt_o)
  );

  pc_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .br_req_i(br_req_i), .br_taken_i(br_taken_i),
    .br_pc4_i(br_pc4_i), .br_imm_i(br_imm_i), .jmp_req_i(jmp_req_i), .jmp_pc4_i(jmp_pc4_i),
    .jmp_addr_i(jmp_addr_i),
`ifdef PC_SEQ_JR_EN
    .jr_req_i(jr_req_i), .jr_addr_i(jr_addr_i),
`endif
    .pc_o(pc_s), .pc4_o(pc4_s), .flush_if_o(fif_s), .flush_id_o(fid_s),
    .redirect_cnt_o(cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall_i = 0; br_req_i = 0; br_taken_i = 0; br_pc4_i = '0; br_imm_i = '0;
    jmp_req_i = 0; jmp_pc4_i = '0; jmp_addr_i = '0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic fl, input logic [31:0] cnt);
    chk({tag, "_pc"}, pc_o, pc);
    chk({tag, "_fif"}, {31'd0, flush_if_o}, {31'd0, fl});
    chk({tag, "_fid"}, {31'd0, flush_id_o}, {31'd0, fl});
    chk({tag, "_cnt"}, {16'd0, cnt_o}, cnt);
  endtask

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk_state("rst_async", 32'h0, 1'b0, 32'd0);
    chk("rst_cnt_sat", {30'd0, cnt_s}, 32'd0);

    // Sequential fetch
    @(negedge clk) rst_n = 1'b1;
    chk_state("seq0", 32'h0, 1'b0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk_state($sformatf("seq%0d", i), 32'(i * 4), 1'b0, 32'd0);
    end
    chk("pc4_16", pc4_o, 32'd20);

    // Taken branch with negative offset
    br_req_i = 1; br_taken_i = 1; br_pc4_i = 32'h100; br_imm_i = 32'hFFFF_FFFE;
    @(negedge clk) idle();
    chk_state("br_tgt", 32'hF8, 1'b1, 32'd1);
    @(negedge clk);
    chk_state("br_after", 32'hFC, 1'b0, 32'd1);

    // Not-taken branch is plain sequential fetch
    br_req_i = 1; br_taken_i = 0; br_pc4_i = 32'h400;
    @(negedge clk) idle();
    chk_state("br_nt", 32'h100, 1'b0, 32'd1);

    // Stall holds
    stall_i = 1;
    @(negedge clk);
    chk_state("stall", 32'h100, 1'b0, 32'd1);

    // Branch + jump + stall collide: branch wins
    br_req_i = 1; br_taken_i = 1; br_pc4_i = 32'h200; br_imm_i = 32'h0;
    jmp_req_i = 1; jmp_pc4_i = 32'hA000_0004; jmp_addr_i = 26'h40;
    @(negedge clk);
    chk_state("coll", 32'h200, 1'b1, 32'd2);
    // Requests and stall stay asserted during FLUSH: all ignored
    br_pc4_i = 32'h1000;
    @(negedge clk) idle();
    chk_state("flush_ign", 32'h204, 1'b0, 32'd2);

    // Lone jump (stall asserted too: jump still wins)
    jmp_req_i = 1; jmp_pc4_i = 32'hA000_0004; jmp_addr_i = 26'h40; stall_i = 1;
    @(negedge clk) idle();
    chk_state("jmp", 32'hA000_0100, 1'b1, 32'd3);
    chk("cnt_sat3", {30'd0, cnt_s}, 32'd3);
    br_req_i = 1; br_taken_i = 1; br_pc4_i = 32'h300;
    @(negedge clk) idle();
    chk_state("jmp_flush_ign", 32'hA000_0104, 1'b0, 32'd3);

    // Branch target wraps to FFFF_FFFC, then pc+4 wraps to 0
    br_req_i = 1; br_taken_i = 1; br_pc4_i = 32'h0; br_imm_i = 32'hFFFF_FFFF;
    @(negedge clk) idle();
    chk_state("wrap_tgt", 32'hFFFF_FFFC, 1'b1, 32'd4);
    chk("wrap_pc4", pc4_o, 32'h0);
    @(negedge clk);
    chk_state("wrap_pc", 32'h0, 1'b0, 32'd4);

    // Fifth redirect: small counter stays saturated
    jmp_req_i = 1; jmp_pc4_i = 32'h10; jmp_addr_i = 26'h3;
    @(negedge clk) idle();
    chk_state("jmp5", 32'hC, 1'b1, 32'd5);
    chk("cnt_sat5", {30'd0, cnt_s}, 32'd3);

    // Reset mid-FLUSH, no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    chk_state("rst_flush", 32'h0, 1'b0, 32'd0);
    chk("rst_flush_sat", {30'd0, cnt_s}, 32'd0);

    // First update at the first rising edge after release
    @(negedge clk) rst_n = 1'b1;
    chk_state("rel0", 32'h0, 1'b0, 32'd0);
    @(negedge clk);
    chk_state("rel1", 32'h4, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
